regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a pending-write scoreboard, sitting between decode/issue and the two writeback paths of the CPU: the single-cycle ALU path on port A and the multi-cycle load/CSR path on port B. It provides NRD combinational read ports with optional same-cycle write forwarding. Per-register busy bits let issue logic stall on operands whose long-latency result has not been written back yet.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and issue marks
- AW (localparam) = $clog2(NREGS)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NRD*AW  read addresses; port k at bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, combinational
- rd_busy  out  NRD  busy bit of each read address, combinational
- wa_en  in  1  port A (ALU) write enable
- wa_addr  in  AW  port A write address
- wa_data  in  XLEN  port A write data
- wb_en  in  1  port B (load/CSR) write enable; clears busy bit
- wb_addr  in  AW  port B write address
- wb_data  in  XLEN  port B write data
- iss_en  in  1  mark destination pending (long-latency op issued)
- iss_addr  in  AW  register to mark busy
- wr_done  out  1  registered; 1 for one cycle after any committed write
- wr_collide  out  1  registered; 1 for one cycle after wa/wb hit the same address

## Operation
- Storage: NREGS×XLEN array plus NREGS busy bits.
- Write commit on the clk edge. A write is effective when its enable is high, rst is low, and the address is not 0 (the last condition applies only when ZERO_REG=1).
- Port A and port B to different addresses: both commit.
- Port A and port B to the same address: port A data commits and port B data is discarded. Port A is the younger instruction. The busy bit is still cleared, and wr_collide pulses the next cycle.
- Busy bits:
  - iss_en sets busy[iss_addr].
  - An effective or collided wb_en clears busy[wb_addr].
  - iss and wb to the same address in the same cycle: set wins.
  - Port A writes do not touch busy.
- Reads:
  - rd_data[k] = array[rd_addr[k]].
  - rd_data[k] is forced to 0 when ZERO_REG=1 and the address is 0.
  - Forwarding behaviour is defined under Configuration.
- rd_busy[k] = busy[rd_addr[k]], the registered value; it is not forwarded from the same-cycle iss or wb.
- wr_done <= effective port A write OR effective port B write.
- Writes or issue marks to address 0 with ZERO_REG=1 are ignored and do not raise wr_done.

## Timing
- Reset (rst high at a clk edge):
  - All registers go to 0, all busy bits to 0, wr_done and wr_collide to 0.
  - Writes and iss presented in the same cycle are dropped.
  - Reset asserted in the middle of a pending load clears its busy bit; a later wb to that address is treated as a normal write.
- Write-to-read latency: 0 cycles with bypass enabled, 1 cycle without.
- Busy latency: iss at edge n means rd_busy is high from cycle n+1. wb at edge m means rd_busy is low from cycle m+1.
- wr_done and wr_collide are single-cycle pulses 1 cycle after the commit edge; back-to-back writes hold them high continuously.

## Configuration
- REGFILE_MP_BYPASS_EN
  - Defined: each read port forwards same-cycle write data when its address matches an effective write. Port A has priority over port B, consistent with commit priority.
  - Undefined: reads return array contents only; a write becomes visible the cycle after its edge. Issue logic must then add one stall cycle on RAW hazards.

## Test plan
- Reset, then read all 32 registers → all return 0x00000000; rd_busy all 0; wr_done 0.
- Write wa x5=0xDEADBEEF while rd_addr[0]=5 in the same cycle:
  - With bypass: rd_data[0]=0xDEADBEEF that cycle.
  - Without bypass: old value 0 that cycle, 0xDEADBEEF the next.
- Same-cycle wa x7=0x11111111 and wb x7=0x22222222 with busy[7]=1 → x7=0x11111111, busy[7]=0, wr_collide=1 for one cycle, wr_done=1.
- iss x9, hold 3 cycles → rd_busy=1; then iss x9 and wb x9=0x55 in the same cycle → busy stays 1 and x9=0x55.
- ZERO_REG=1: wa x0=0xFFFFFFFF, iss x0 → x0 reads 0, busy[0]=0, wr_done stays 0.
- iss x12, assert rst for 1 cycle, then wb x12=0xA5 → busy[12]=0 after reset, x12=0xA5, wr_done pulses.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with pending-write scoreboard
// Optional same-cycle write forwarding on reads: define REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                wr_done,
  output logic                wr_collide
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic wr_done_q, wr_done_d;
  logic wr_collide_q, wr_collide_d;

  logic wa_eff, wb_eff, iss_eff, collide;
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rv;

  // Address 0 is hardwired only when ZERO_REG is set; reset also kills all writes.
  always_comb begin
    wa_eff  = wa_en  && !rst && !((ZERO_REG != 0) && (wa_addr  == '0));
    wb_eff  = wb_en  && !rst && !((ZERO_REG != 0) && (wb_addr  == '0));
    iss_eff = iss_en && !rst && !((ZERO_REG != 0) && (iss_addr == '0));
    collide = wa_eff && wb_eff && (wa_addr == wb_addr);
  end

  always_comb begin
    mem_d        = mem_q;
    busy_d       = busy_q;
    wr_done_d    = wa_eff || wb_eff;
    wr_collide_d = collide;
    // Port A is the younger instruction, so its data wins a same-address collision.
    if (wb_eff && !collide) mem_d[wb_addr] = wb_data;
    if (wa_eff) mem_d[wa_addr] = wa_data;
    if (wb_eff) busy_d[wb_addr] = 1'b0;
    if (iss_eff) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      busy_q       <= '0;
      wr_done_q    <= 1'b0;
      wr_collide_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
      busy_q       <= busy_d;
      wr_done_q    <= wr_done_d;
      wr_collide_q <= wr_collide_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rv      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      rv = mem_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (wa_eff && (wa_addr == ra)) rv = wa_data;
      else if (wb_eff && (wb_addr == ra)) rv = wb_data;
`endif
      if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
      rd_data[k*XLEN +: XLEN] = rv;
      rd_busy[k] = busy_q[ra];
    end
  end

  assign wr_done    = wr_done_q;
  assign wr_collide = wr_collide_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
// Expectations follow REGFILE_MP_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wa_en, wb_en, iss_en;
  logic [AW-1:0]       wa_addr, wb_addr, iss_addr;
  logic [XLEN-1:0]     wa_data, wb_data;
  logic                wr_done, wr_collide;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .wr_done(wr_done), .wr_collide(wr_collide)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  function automatic logic [31:0] rd0();
    return rd_data[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return rd_data[63:32];
  endfunction

  initial begin
    rst = 1'b1; rd_addr = '0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    tick();
    rst = 1'b0;
    check("rst_done", 32'(wr_done), 32'd0);
    check("rst_collide", 32'(wr_collide), 32'd0);
    for (int i = 0; i < 32; i++) begin
      set_rd(AW'(i), AW'(31 - i));
      check("rst_rd0", rd0(), 32'h0);
      check("rst_rd1", rd1(), 32'h0);
      check("rst_busy", 32'(rd_busy), 32'd0);
    end

    // Port A write with a same-cycle read of the same register
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    set_rd(5'd5, 5'd0);
`ifdef REGFILE_MP_BYPASS_EN
    check("x5_same_cycle", rd0(), 32'hDEADBEEF);
`else
    check("x5_same_cycle", rd0(), 32'h0);
`endif
    tick(); idle(); #1;
    check("x5_next", rd0(), 32'hDEADBEEF);
    check("x5_done", 32'(wr_done), 32'd1);
    check("x5_no_collide", 32'(wr_collide), 32'd0);
    tick();
    check("done_pulse_end", 32'(wr_done), 32'd0);

    // Collision on x7 while x7 is busy
    iss_en = 1'b1; iss_addr = 5'd7;
    tick(); idle();
    set_rd(5'd5, 5'd7);
    check("x7_busy", 32'(rd_busy[1]), 32'd1);
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11111111;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22222222;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    check("x7_fwd_prio", rd1(), 32'h11111111);
`else
    check("x7_old", rd1(), 32'h0);
`endif
    check("x7_busy_not_fwd", 32'(rd_busy[1]), 32'd1);
    tick(); idle(); #1;
    check("x7_data", rd1(), 32'h11111111);
    check("x7_busy_clr", 32'(rd_busy[1]), 32'd0);
    check("x7_collide", 32'(wr_collide), 32'd1);
    check("x7_done", 32'(wr_done), 32'd1);
    tick();
    check("collide_pulse_end", 32'(wr_collide), 32'd0);

    // Two ports to different registers both commit
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h33;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    tick(); idle();
    set_rd(5'd3, 5'd4);
    check("x3_data", rd0(), 32'h33);
    check("x4_data", rd1(), 32'h44);
    check("diff_no_collide", 32'(wr_collide), 32'd0);
    check("diff_done", 32'(wr_done), 32'd1);

    // Issue x9, hold, then same-cycle iss+wb: set wins
    iss_en = 1'b1; iss_addr = 5'd9;
    tick(); idle();
    set_rd(5'd9, 5'd9);
    for (int c = 0; c < 3; c++) begin
      check("x9_busy_hold", 32'(rd_busy[0]), 32'd1);
      tick();
    end
    iss_en = 1'b1; iss_addr = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    tick(); idle(); #1;
    check("x9_set_wins", 32'(rd_busy[0]), 32'd1);
    check("x9_data", rd0(), 32'h55);
    check("x9_done", 32'(wr_done), 32'd1);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h66;
    tick(); idle(); #1;
    check("x9_wb_clear", 32'(rd_busy[1]), 32'd0);
    check("x9_data2", rd1(), 32'h66);
    tick();

    // Register 0 ignores writes and issue marks
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    set_rd(5'd0, 5'd5);
    check("x0_same_cycle", rd0(), 32'h0);
    tick(); idle(); #1;
    check("x0_data", rd0(), 32'h0);
    check("x0_busy", 32'(rd_busy[0]), 32'd0);
    check("x0_no_done", 32'(wr_done), 32'd0);
    check("x0_no_collide", 32'(wr_collide), 32'd0);

    // Reset in the middle of a pending load
    iss_en = 1'b1; iss_addr = 5'd12;
    tick(); idle();
    set_rd(5'd12, 5'd13);
    check("x12_busy", 32'(rd_busy[0]), 32'd1);
    rst = 1'b1;
    wa_en = 1'b1; wa_addr = 5'd13; wa_data = 32'h1313;
    tick(); idle(); rst = 1'b0; #1;
    check("rst_x12_busy", 32'(rd_busy[0]), 32'd0);
    check("rst_x13_dropped", rd1(), 32'h0);
    check("rst_done_clr", 32'(wr_done), 32'd0);
    set_rd(5'd5, 5'd12);
    check("rst_x5_cleared", rd0(), 32'h0);
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hA5;
    tick(); idle(); #1;
    check("x12_data", rd1(), 32'hA5);
    check("x12_busy_after", 32'(rd_busy[1]), 32'd0);
    check("x12_done", 32'(wr_done), 32'd1);
    tick();
    check("x12_done_end", 32'(wr_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
